press_decoder: RTL

PRESS_DECODER -- requirements
Module: press_decoder

---
 rtl/press_decoder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/press_decoder.sv
// Button press classifier: SHORT / LONG (and DOUBLE when PRESS_DECODER_DOUBLE_EN is
// defined) from a filtered level, counted in enable ticks, with a one-deep event register.
module press_decoder #(
    parameter int unsigned width      = 16,
    parameter int unsigned long_count = 500,
    parameter int unsigned gap_count  = 250
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             in,
    input  logic             valid,
    output logic             event_valid,
    input  logic             event_ready,
    output logic [1:0]       event_code,
    output logic [width-1:0] event_duration,
    output logic             overrun
);

`ifdef PRESS_DECODER_DOUBLE_EN
    typedef enum logic [1:0] {IDLE, PRESS, GAP, PRESS2} state_t;
`else
    typedef enum logic {IDLE, PRESS} state_t;
`endif

    localparam logic [1:0] CODE_SHORT  = 2'b01;
    localparam logic [1:0] CODE_LONG   = 2'b10;
`ifdef PRESS_DECODER_DOUBLE_EN
    localparam logic [1:0] CODE_DOUBLE = 2'b11;
`endif

    state_t           state;
    logic [width-1:0] dur;
`ifdef PRESS_DECODER_DOUBLE_EN
    logic [width-1:0] gap;
    logic [width-1:0] saved;
    logic [width-1:0] gap_inc;
`endif

    logic             emit;
    logic [1:0]       emit_code;
    logic [width-1:0] emit_dur;

    function automatic logic [width-1:0] sat_inc(input logic [width-1:0] v);
        return (&v) ? v : v + width'(1);
    endfunction

`ifdef PRESS_DECODER_DOUBLE_EN
    assign gap_inc = sat_inc(gap);
`endif

    // Event decision for the current tick; loaded into the event register below.
    always_comb begin
        emit      = 1'b0;
        emit_code = 2'b00;
        emit_dur  = '0;
        if (valid && enable) begin
            case (state)
                PRESS: begin
                    if (!in) begin
                        if (32'(dur) >= long_count) begin
                            emit      = 1'b1;
                            emit_code = CODE_LONG;
                            emit_dur  = dur;
                        end
`ifdef PRESS_DECODER_DOUBLE_EN
                        else if (gap_count <= 1) begin
                            emit      = 1'b1;
                            emit_code = CODE_SHORT;
                            emit_dur  = dur;
                        end
`else
                        else begin
                            emit      = 1'b1;
                            emit_code = CODE_SHORT;
                            emit_dur  = dur;
                        end
`endif
                    end
                end
`ifdef PRESS_DECODER_DOUBLE_EN
                GAP: begin
                    if (!in && 32'(gap_inc) == gap_count) begin
                        emit      = 1'b1;
                        emit_code = CODE_SHORT;
                        emit_dur  = saved;
                    end
                end
                PRESS2: begin
                    if (!in) begin
                        emit      = 1'b1;
                        emit_code = CODE_DOUBLE;
                        emit_dur  = dur;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            dur            <= '0;
`ifdef PRESS_DECODER_DOUBLE_EN
            gap            <= '0;
            saved          <= '0;
`endif
            event_valid    <= 1'b0;
            event_code     <= 2'b00;
            event_duration <= '0;
            overrun        <= 1'b0;
        end else begin
            if (emit) begin
                if (!event_valid || event_ready) begin
                    event_valid    <= 1'b1;
                    event_code     <= emit_code;
                    event_duration <= emit_dur;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (event_valid && event_ready) begin
                event_valid    <= 1'b0;
                event_code     <= 2'b00;
                event_duration <= '0;
            end

            if (!valid) begin
                state <= IDLE;
                dur   <= '0;
`ifdef PRESS_DECODER_DOUBLE_EN
                gap   <= '0;
                saved <= '0;
`endif
            end else if (enable) begin
                case (state)
                    IDLE: begin
                        if (in) begin
                            state <= PRESS;
                            dur   <= width'(1);
                        end
                    end
                    PRESS: begin
                        if (in) begin
                            dur <= sat_inc(dur);
                        end else if (32'(dur) >= long_count) begin
                            state <= IDLE;
                            dur   <= '0;
                        end else begin
`ifdef PRESS_DECODER_DOUBLE_EN
                            // The release tick is the first tick of the gap.
                            if (gap_count <= 1) begin
                                state <= IDLE;
                            end else begin
                                state <= GAP;
                                saved <= dur;
                                gap   <= width'(1);
                            end
`else
                            state <= IDLE;
`endif
                            dur <= '0;
                        end
                    end
`ifdef PRESS_DECODER_DOUBLE_EN
                    GAP: begin
                        if (in) begin
                            state <= PRESS2;
                            dur   <= width'(1);
                            gap   <= '0;
                        end else if (32'(gap_inc) == gap_count) begin
                            state <= IDLE;
                            gap   <= '0;
                            saved <= '0;
                        end else begin
                            gap <= gap_inc;
                        end
                    end
                    PRESS2: begin
                        if (in) begin
                            dur <= sat_inc(dur);
                        end else begin
                            state <= IDLE;
                            dur   <= '0;
                            saved <= '0;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
